mem_wb_pipe_stage: RTL
======================

// Module: mem_wb_pipe_stage
// PURPOSE
//  - Parametrised MEM->WB pipeline register: DEPTH back-to-back stages carrying ALU result,
//    memory read data, destination register and writeback control.
//  - Adds sync reset, per-stage valid, bubble insertion and flush on top of the plain stall hold.
//  - Sits between data-memory access and register-file writeback. Exposes every stage's
//    rd/wr_ctrl/valid so the forwarding unit can see in-flight writers.
// PARAMETERS
//  - DATA_W  32  width of alu_result and mem_data fields
//  - REG_W   5   width of destination register index
//  - CTRL_W  2   width of writeback control field (0 = no writeback)
//  - DEPTH   1   number of register stages, >=1; stage DEPTH-1 drives the wb_* outputs
//  - CNT_W   16  stall counter width (used only with PIPE_STAGE_STALL_CNT_EN)
// PORTS
//  - clk            in   1              rising-edge clock
//  - rst            in   1              synchronous, active-high reset
//  - stall          in   1              1 = every stage holds its contents
//  - flush          in   1              1 = invalidate every stage
//  - mem_valid      in   1              incoming slot holds a real instruction
//  - mem_alu_result in   DATA_W         ALU result from MEM
//  - mem_data       in   DATA_W         load data from MEM
//  - mem_rd         in   REG_W          destination register
//  - mem_wr_ctrl    in   CTRL_W         writeback control
//  - wb_valid       out  1              output stage valid
//  - wb_alu_result  out  DATA_W         to WB mux
//  - wb_mem_data    out  DATA_W         to WB mux
//  - wb_rd          out  REG_W          to register file
//  - wb_wr_ctrl     out  CTRL_W         to WB; 0 whenever wb_valid=0
//  - fwd_valid      out  DEPTH          valid of stage i (bit i)
//  - fwd_rd         out  DEPTH*REG_W    rd of stage i at [i*REG_W +: REG_W]
//  - fwd_wr_ctrl    out  DEPTH*CTRL_W   wr_ctrl of stage i at [i*CTRL_W +: CTRL_W]
//  - stall_cnt      out  CNT_W          only with PIPE_STAGE_STALL_CNT_EN
// BEHAVIOUR
//  - All state updates on posedge clk. Priority: rst > flush > stall > advance.
//  - rst=1: every stage valid=0, alu_result=0, mem_data=0, rd=0, wr_ctrl=0, so all outputs are 0
//    on the next cycle. Overrides a flush, stall or transfer in progress.
//  - flush=1 (rst=0): every stage valid=0 and wr_ctrl=0. alu_result, mem_data and rd hold.
//    The input slot is not captured. Flush wins over a simultaneous stall.
//  - stall=1 (rst=0, flush=0): all stages hold every field bit-exact. Input is dropped;
//    the upstream stage must also be stalled.
//  - advance (rst=0, flush=0, stall=0):
//    - stage 0 <= inputs; stage i <= stage i-1; the last stage's content retires.
//    - mem_valid=0 captures a bubble: valid=0, wr_ctrl forced to 0, other fields captured as
//      presented.
//  - Latency: exactly DEPTH unstalled cycles from a mem_* sample to the wb_* outputs.
//    Throughput is 1 per cycle.
//  - Invariant: any stage with valid=0 has wr_ctrl=0, so no spurious register-file write or
//    forward is possible.
//  - All outputs come straight from registers; no combinational input-to-output path.
//  - DEPTH=1 behaves as a single stall-able register with valid/flush/reset.
// CONFIGURATION
//  - PIPE_STAGE_STALL_CNT_EN defined:
//    - stall_cnt port exists.
//    - Increments by 1 each cycle with stall=1 and flush=0 (rst=0); saturates at 2**CNT_W-1.
//    - rst=1 clears it to 0; flush does not clear it.
//  - PIPE_STAGE_STALL_CNT_EN undefined: no stall_cnt port, no counter logic.
//    All other behaviour is identical.
// TESTING
//  - Reset: drive junk inputs, rst=1 for 2 cycles.
//    -> all wb_* = 0, fwd_valid = 0, stall_cnt = 0.
//  - Pass-through, DEPTH=3: stream rd=1,2,3,4 with wr_ctrl=2'b01, valid=1.
//    -> wb_rd = 1,2,3,4 appears exactly 3 cycles after each sample; fwd_rd tracks per stage.
//  - Stall: with alu_result=32'hDEADBEEF in stage 0, hold stall=1 for 4 cycles.
//    -> all fields are unchanged for 4 cycles; stall_cnt = 4 (macro on); new inputs are dropped.
//  - Bubble: mem_valid=0 with mem_wr_ctrl=2'b11.
//    -> the corresponding wb_valid=0 and wb_wr_ctrl=0.
//  - Flush+stall in the same cycle with 3 valid stages.
//    -> next cycle fwd_valid=0, every wr_ctrl=0, rd/data held, stall_cnt unchanged.
//  - Saturation (CNT_W=3): stall for 10 cycles -> stall_cnt stops at 7.
//    Then assert rst mid-stall -> stall_cnt = 0 and all stages cleared.

Source files
------------

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: DEPTH-deep MEM->WB register (valid/bubble/flush/stall, per-stage rd/wr_ctrl/valid forwarding taps, wb_* from last stage; stall_cnt port only with PIPE_STAGE_STALL_CNT_EN)
module mem_wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 2,
  parameter int DEPTH  = 1
`ifdef PIPE_STAGE_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      mem_valid,
  input  logic [DATA_W-1:0]         mem_alu_result,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic [REG_W-1:0]          mem_rd,
  input  logic [CTRL_W-1:0]         mem_wr_ctrl,
  output logic                      wb_valid,
  output logic [DATA_W-1:0]         wb_alu_result,
  output logic [DATA_W-1:0]         wb_mem_data,
  output logic [REG_W-1:0]          wb_rd,
  output logic [CTRL_W-1:0]         wb_wr_ctrl,
  output logic [DEPTH-1:0]          fwd_valid,
  output logic [DEPTH*REG_W-1:0]    fwd_rd,
  output logic [DEPTH*CTRL_W-1:0]   fwd_wr_ctrl
`ifdef PIPE_STAGE_STALL_CNT_EN
  , output logic [CNT_W-1:0]        stall_cnt
`endif
);
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][DATA_W-1:0] alu_q, alu_d, data_q, data_d;
  logic [DEPTH-1:0][REG_W-1:0]  rd_q, rd_d;
  logic [DEPTH-1:0][CTRL_W-1:0] wr_q, wr_d;
  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (flush) begin
      valid_d = '0;
      wr_d    = '0;
    end else if (!stall) begin
      valid_d[0] = mem_valid;
      alu_d[0]   = mem_alu_result;
      data_d[0]  = mem_data;
      rd_d[0]    = mem_rd;
      wr_d[0]    = mem_valid ? mem_wr_ctrl : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        alu_d[i]   = alu_q[i-1];
        data_d[i]  = data_q[i-1];
        rd_d[i]    = rd_q[i-1];
        wr_d[i]    = wr_q[i-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      alu_q   <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  assign wb_valid      = valid_q[DEPTH-1];
  assign wb_alu_result = alu_q[DEPTH-1];
  assign wb_mem_data   = data_q[DEPTH-1];
  assign wb_rd         = rd_q[DEPTH-1];
  assign wb_wr_ctrl    = wr_q[DEPTH-1];
  assign fwd_valid     = valid_q;
  assign fwd_rd        = rd_q;
  assign fwd_wr_ctrl   = wr_q;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (stall && !flush && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign stall_cnt = cnt_q;
`endif
endmodule
